// File: rtl/matvec_stream_controller_if.sv
// Stream and multiplier-operand bundle for matvec_stream_controller.
// Master side is the controller; slave side is the surrounding datapath and multiplier.
// Parameters must match the controller instance that uses it.
interface matvec_stream_controller_if #(
  parameter int N     = 32,
  parameter int LEN   = 4,
  parameter int WIDTH = 4
);
  // serial operand input
  logic                             in_valid;
  logic                             in_ready;
  logic [N-1:0]                     in_data;
  // serial result output
  logic                             out_valid;
  logic                             out_ready;
  logic [N-1:0]                     out_data;
  logic                             out_last;
  logic                             busy;
  // wide ports toward the combinational multiplier
  logic [LEN-1:0][N-1:0]            mm_vector;
  logic [WIDTH-1:0][LEN-1:0][N-1:0] mm_matrix;
  logic [WIDTH-1:0][N-1:0]          mm_result;

  modport master (
    input  in_valid, in_data, out_ready, mm_result,
    output in_ready, out_valid, out_data, out_last, busy, mm_vector, mm_matrix
  );

  modport slave (
    output in_valid, in_data, out_ready, mm_result,
    input  in_ready, out_valid, out_data, out_last, busy, mm_vector, mm_matrix
  );
endinterface

// File: rtl/matvec_stream_controller.sv
// Serial-to-parallel front end and parallel-to-serial back end for the matrix-vector multiplier.
// Latency: result word 0 valid CALC_CYCLES edges after the last operand word is accepted.
// Backpressure: input stalls through COMPUTE/DRAIN; output holds data/last/index while out_ready is low.
module matvec_stream_controller #(
  parameter int N           = 32,
  parameter int LEN         = 4,
  parameter int WIDTH       = 4,
  parameter int CALC_CYCLES = 1
) (
  input logic                       clk,
  input logic                       reset,
  matvec_stream_controller_if.master bus
);

  localparam int T  = LEN * (WIDTH + 1);
  localparam int LW = (T > 1) ? $clog2(T) : 1;
  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam logic [LW-1:0] LOAD_LAST = LW'(T - 1);
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

  logic [1:0]                       state_q, state_d;
  logic [LW-1:0]                    load_cnt_q, load_cnt_d;
  logic [CW-1:0]                    calc_cnt_q, calc_cnt_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [LEN-1:0][N-1:0]            vec_q, vec_d;
  logic [WIDTH-1:0][LEN-1:0][N-1:0] mat_q, mat_d;
  logic [WIDTH-1:0][N-1:0]          result_q, result_d;

  logic in_fire;
  logic out_fire;

  // ready/valid are pure state decodes, so the handshakes reduce to state plus the peer's strobe
  assign in_fire  = (state_q == ST_LOAD)  && bus.in_valid;
  assign out_fire = (state_q == ST_DRAIN) && bus.out_ready;

  // Route the accepted word into its operand slot: vector first, then matrix row-major
  always_comb begin
    vec_d = vec_q;
    mat_d = mat_q;
    if (in_fire) begin
      for (int c = 0; c < LEN; c++) begin
        if (load_cnt_q == LW'(c)) vec_d[c] = bus.in_data;
      end
      for (int r = 0; r < WIDTH; r++) begin
        for (int c = 0; c < LEN; c++) begin
          if (load_cnt_q == LW'(LEN + r * LEN + c)) mat_d[r][c] = bus.in_data;
        end
      end
    end
  end

  // Job sequencing: LOAD -> COMPUTE -> DRAIN -> LOAD
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    calc_cnt_d = calc_cnt_q;
    idx_d      = idx_q;
    result_d   = result_q;
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          if (load_cnt_q == LOAD_LAST) begin
            load_cnt_d = '0;
            calc_cnt_d = '0;
            state_d    = ST_COMPUTE;
          end else begin
            load_cnt_d = load_cnt_q + LW'(1);
          end
        end
      end
      ST_COMPUTE: begin
        // operands have been stable for CALC_CYCLES cycles on this edge
        if (calc_cnt_q == CALC_LAST) begin
          result_d = bus.mm_result;
          idx_d    = '0;
          state_d  = ST_DRAIN;
        end else begin
          calc_cnt_d = calc_cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial load or undrained result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      calc_cnt_q <= '0;
      idx_q      <= '0;
      vec_q      <= '0;
      mat_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      calc_cnt_q <= calc_cnt_d;
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      mat_q      <= mat_d;
      result_q   <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.busy      = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
  assign bus.out_last  = (state_q == ST_DRAIN) && (idx_q == IDX_LAST);
  // zero outside DRAIN so the output bus is quiet between jobs
  assign bus.out_data  = (state_q == ST_DRAIN) ? result_q[idx_q] : '0;
  assign bus.mm_vector = vec_q;
  assign bus.mm_matrix = mat_q;

endmodule

// File: tb/tb_matvec_stream_controller.sv
// Directed bench for matvec_stream_controller with a fixed-point (B=8) multiplier model.
// Inputs change and outputs are sampled on the falling clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_matvec_stream_controller;

  localparam int N  = 32;
  localparam int B  = 8;
  localparam int CC = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  matvec_stream_controller_if #(.N(N), .LEN(4), .WIDTH(4)) bus ();

  matvec_stream_controller #(.N(N), .LEN(4), .WIDTH(4), .CALC_CYCLES(CC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational fixed-point multiplier model driving mm_result
  always_comb begin
    logic signed [63:0] acc;
    logic signed [63:0] sh;
    acc = '0;
    sh  = '0;
    bus.mm_result = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) begin
        acc = acc + ($signed(bus.mm_matrix[r][c]) * $signed(bus.mm_vector[c]));
      end
      sh = acc >>> B;
      bus.mm_result[r] = sh[31:0];
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stream nwords of a job; gaps inserts one idle cycle before every word
  task automatic push_job(input logic [3:0][31:0] v, input logic [15:0][31:0] m,
                          input bit gaps, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      int n;
      if (gaps) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (i < 4) ? v[i] : m[i-4];
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("push_ready_w%0d", i), (n < 100), 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // called at the falling edge right after the last word was accepted
  task automatic wait_result(input bit junk);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        check("compute_in_ready", bus.in_ready, 0);
        check("compute_busy", bus.busy, 1);
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("latency", n, CC);
  endtask

  // drain four result words; bp selects the index held under backpressure (-1 none)
  task automatic drain(input logic [3:0][31:0] exp, input int bp);
    for (int i = 0; i < 4; i++) begin
      if (i == bp) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("bp_valid_%0d", k), bus.out_valid, 1);
          check($sformatf("bp_data_%0d", k), bus.out_data, exp[i]);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
      check($sformatf("out_valid_%0d", i), bus.out_valid, 1);
      check($sformatf("out_data_%0d", i), bus.out_data, exp[i]);
      check($sformatf("out_last_%0d", i), bus.out_last, (i == 3));
      check($sformatf("drain_in_ready_%0d", i), bus.in_ready, 0);
      check($sformatf("drain_busy_%0d", i), bus.busy, 1);
      @(negedge clk);
    end
    check("post_in_ready", bus.in_ready, 1);
    check("post_busy", bus.busy, 0);
    check("post_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    logic [3:0][31:0]  va, vb, ra, rb;
    logic [15:0][31:0] ma, mb;

    checks = 0;
    errors = 0;

    // job A: identity matrix, results equal the vector
    va = {32'h400, 32'h300, 32'h200, 32'h100};
    ma = '0;
    ma[0] = 32'h100; ma[5] = 32'h100; ma[10] = 32'h100; ma[15] = 32'h100;
    ra = {32'h400, 32'h300, 32'h200, 32'h100};

    // job B: all-ones vector, mixed rows incl. a negative entry
    vb = {32'h100, 32'h100, 32'h100, 32'h100};
    mb = '0;
    mb[0]  = 32'h100; mb[1]  = 32'h200;
    mb[4]  = 32'h80;  mb[5]  = 32'h80;  mb[6]  = 32'h80;  mb[7]  = 32'h80;
    mb[8]  = 32'hFFFF_FF00;
    mb[12] = 32'h300; mb[13] = 32'h100; mb[14] = 32'h100; mb[15] = 32'h100;
    rb = {32'h600, 32'hFFFF_FF00, 32'h200, 32'h300};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_vector", bus.mm_vector, 0);
    check("rst_matrix", bus.mm_matrix, 0);
    reset = 1'b0;
    @(negedge clk);

    // identity job, junk input offered during COMPUTE, settle time checked
    push_job(va, ma, 1'b0, 20);
    wait_result(1'b1);
    drain(ra, -1);
    check("vec_unchanged_by_junk", bus.mm_vector, va);

    // same job with gapped input; all slots verified before the result appears
    push_job(va, ma, 1'b1, 20);
    check("gap_vector", bus.mm_vector, va);
    check("gap_matrix", bus.mm_matrix, ma);
    wait_result(1'b0);
    drain(ra, -1);

    // job B with output backpressure at index 1
    push_job(vb, mb, 1'b0, 20);
    wait_result(1'b0);
    drain(rb, 1);

    // reset after 7 words of job B
    push_job(vb, mb, 1'b0, 7);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_vector", bus.mm_vector, 0);
    check("mid_rst_matrix", bus.mm_matrix, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // full job B, then job A back to back with no idle cycle
    push_job(vb, mb, 1'b0, 20);
    check("after_rst_matrix", bus.mm_matrix, mb);
    wait_result(1'b0);
    drain(rb, -1);
    push_job(va, ma, 1'b0, 20);
    wait_result(1'b0);
    drain(ra, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
